// File: rtl/rx_block_lock_mon_if.sv
// ============================================================================
// Module   : rx_block_lock_mon_if
// Brief    : Signal bundle between the GT RX gearbox side and the 64b/66b
//            block-lock monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_block_lock_mon_if;
  logic        rx_reset_done;    // GT RX reset done, already in clk domain
  logic        rx_header_valid;  // rx_header carries a sync header this cycle
  logic [1:0]  rx_header;        // 66b sync header
  logic        rx_status;        // block locked
  logic        rx_slip;          // one-cycle gearbox slip request
  logic [15:0] bad_hdr_cnt;      // saturating bad-header count while locked

  // Gearbox / transceiver side: produces headers, consumes lock and slip
  modport master (
    output rx_reset_done,
    output rx_header_valid,
    output rx_header,
    input  rx_status,
    input  rx_slip,
    input  bad_hdr_cnt
  );

  // Lock monitor side
  modport slave (
    input  rx_reset_done,
    input  rx_header_valid,
    input  rx_header,
    output rx_status,
    output rx_slip,
    output bad_hdr_cnt
  );
endinterface

`default_nettype wire

// File: rtl/rx_block_lock_mon.sv
// ============================================================================
// Module   : rx_block_lock_mon
// Brief    : 64b/66b block-lock acquisition and monitoring. Hunts for
//            LOCK_CNT consecutive good sync headers, slips the gearbox on a
//            bad header, and drops lock when BAD_MAX bad headers arrive
//            within one WINDOW of valid headers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_block_lock_mon #(
  parameter int LOCK_CNT  = 64,
  parameter int WINDOW    = 1024,
  parameter int BAD_MAX   = 16,
  parameter int SLIP_WAIT = 32
) (
  input  logic                clk,
  input  logic                reset,
  rx_block_lock_mon_if.slave  bus
);

  localparam int c_GW = $clog2(LOCK_CNT + 1);
  localparam int c_WW = $clog2(WINDOW + 1);
  localparam int c_BW = $clog2(BAD_MAX + 1);
  localparam int c_SW = $clog2(SLIP_WAIT + 1);

  // Terminal values: each counter clears when it reaches its last value, so
  // none of them can wrap.
  localparam logic [c_GW-1:0] c_GOOD_LAST = c_GW'(LOCK_CNT - 1);
  localparam logic [c_WW-1:0] c_WIN_LAST  = c_WW'(WINDOW - 1);
  localparam logic [c_BW-1:0] c_BAD_LAST  = c_BW'(BAD_MAX - 1);
  localparam logic [c_SW-1:0] c_SLIP_LAST = c_SW'(SLIP_WAIT - 1);
  localparam logic [c_GW-1:0] c_GOOD_ONE  = c_GW'(1);
  localparam logic [c_WW-1:0] c_WIN_ONE   = c_WW'(1);
  localparam logic [c_BW-1:0] c_BAD_ONE   = c_BW'(1);
  localparam logic [c_SW-1:0] c_SLIP_ONE  = c_SW'(1);
  localparam logic [15:0]     c_HDR_MAX   = 16'hFFFF;

  // One-hot state encoding
  typedef enum logic [3:0] {
    S_IDLE      = 4'b0001,
    S_HUNT      = 4'b0010,
    S_SLIP_WAIT = 4'b0100,
    S_LOCKED    = 4'b1000
  } state_t;

  state_t           r_state,       w_state_nxt;
  logic [c_GW-1:0]  r_good_cnt,    w_good_cnt_nxt;
  logic [c_WW-1:0]  r_win_cnt,     w_win_cnt_nxt;
  logic [c_BW-1:0]  r_bad_cnt,     w_bad_cnt_nxt;
  logic [c_SW-1:0]  r_slip_cnt,    w_slip_cnt_nxt;
  logic             r_slip,        w_slip_nxt;
  logic [15:0]      r_bad_hdr_cnt, w_bad_hdr_cnt_nxt;

  logic w_hdr_valid;
  logic w_hdr_good;

  assign w_hdr_valid = bus.rx_header_valid;
  // 01 and 10 are the only legal sync headers
  assign w_hdr_good  = bus.rx_header[1] ^ bus.rx_header[0];

  // Next-state and counter update; loss of rx_reset_done overrides everything
  always_comb begin
    w_state_nxt       = r_state;
    w_good_cnt_nxt    = r_good_cnt;
    w_win_cnt_nxt     = r_win_cnt;
    w_bad_cnt_nxt     = r_bad_cnt;
    w_slip_cnt_nxt    = r_slip_cnt;
    w_slip_nxt        = 1'b0;
    w_bad_hdr_cnt_nxt = r_bad_hdr_cnt;

    if (!bus.rx_reset_done) begin
      w_state_nxt    = S_IDLE;
      w_good_cnt_nxt = '0;
      w_win_cnt_nxt  = '0;
      w_bad_cnt_nxt  = '0;
      w_slip_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt    = S_HUNT;
          w_good_cnt_nxt = '0;
        end

        S_HUNT: begin
          if (w_hdr_valid) begin
            if (w_hdr_good) begin
              if (r_good_cnt == c_GOOD_LAST) begin
                w_state_nxt    = S_LOCKED;
                w_good_cnt_nxt = '0;
                w_win_cnt_nxt  = '0;
                w_bad_cnt_nxt  = '0;
              end else begin
                w_good_cnt_nxt = r_good_cnt + c_GOOD_ONE;
              end
            end else begin
              // Misaligned: slip once, then let the gearbox settle
              w_state_nxt    = S_SLIP_WAIT;
              w_good_cnt_nxt = '0;
              w_slip_cnt_nxt = '0;
              w_slip_nxt     = 1'b1;
            end
          end
        end

        S_SLIP_WAIT: begin
          // Counts every cycle; headers are meaningless while the gearbox slips
          if (r_slip_cnt == c_SLIP_LAST) begin
            w_state_nxt    = S_HUNT;
            w_good_cnt_nxt = '0;
            w_slip_cnt_nxt = '0;
          end else begin
            w_slip_cnt_nxt = r_slip_cnt + c_SLIP_ONE;
          end
        end

        S_LOCKED: begin
          if (w_hdr_valid) begin
            if (!w_hdr_good && (r_bad_hdr_cnt != c_HDR_MAX)) begin
              w_bad_hdr_cnt_nxt = r_bad_hdr_cnt + 16'd1;
            end
            // Loss of lock is checked first so it wins over window completion
            if (!w_hdr_good && (r_bad_cnt == c_BAD_LAST)) begin
              w_state_nxt    = S_HUNT;
              w_good_cnt_nxt = '0;
              w_win_cnt_nxt  = '0;
              w_bad_cnt_nxt  = '0;
            end else if (r_win_cnt == c_WIN_LAST) begin
              w_win_cnt_nxt = '0;
              w_bad_cnt_nxt = '0;
            end else begin
              w_win_cnt_nxt = r_win_cnt + c_WIN_ONE;
              if (!w_hdr_good) begin
                w_bad_cnt_nxt = r_bad_cnt + c_BAD_ONE;
              end
            end
          end
        end

        default: begin
          w_state_nxt    = S_IDLE;
          w_good_cnt_nxt = '0;
          w_win_cnt_nxt  = '0;
          w_bad_cnt_nxt  = '0;
          w_slip_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_good_cnt    <= '0;
      r_win_cnt     <= '0;
      r_bad_cnt     <= '0;
      r_slip_cnt    <= '0;
      r_slip        <= 1'b0;
      r_bad_hdr_cnt <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_good_cnt    <= w_good_cnt_nxt;
      r_win_cnt     <= w_win_cnt_nxt;
      r_bad_cnt     <= w_bad_cnt_nxt;
      r_slip_cnt    <= w_slip_cnt_nxt;
      r_slip        <= w_slip_nxt;
      r_bad_hdr_cnt <= w_bad_hdr_cnt_nxt;
    end
  end

  // Lock status is a pure state decode so it falls the cycle lock is lost
  assign bus.rx_status   = (r_state == S_LOCKED);
  assign bus.rx_slip     = r_slip;
  assign bus.bad_hdr_cnt = r_bad_hdr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rx_block_lock_mon.sv
// ============================================================================
// Module   : tb_rx_block_lock_mon
// Brief    : Directed, table-driven bench for rx_block_lock_mon. A default-
//            parameter instance walks lock / window / slip / stall scenarios;
//            a small-parameter instance drives bad_hdr_cnt to saturation and
//            then takes a reset during a slip pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_block_lock_mon;

  logic clk;
  logic rst_m;
  logic rst_s;

  int n_checks;
  int n_fail;

  rx_block_lock_mon_if m_if ();
  rx_block_lock_mon_if s_if ();

  rx_block_lock_mon dut (
    .clk   (clk),
    .reset (rst_m),
    .bus   (m_if)
  );

  rx_block_lock_mon #(
    .LOCK_CNT  (1),
    .WINDOW    (255),
    .BAD_MAX   (255),
    .SLIP_WAIT (2)
  ) dut_sat (
    .clk   (clk),
    .reset (rst_s),
    .bus   (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vmode: 0 = never valid, 1 = always valid, 2 = valid on even cycles only
  typedef struct {
    string       name;
    int          n;
    bit          rd;
    int          vmode;
    logic [1:0]  hdr;
    int          per;      // every per-th valid header is 2'b11 (0 = none)
    bit          e_st;
    bit          e_slip;
    int          e_slips;  // slip-high cycles expected within the segment
    logic [15:0] e_bad;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, int n, bit rd, int vmode,
                              logic [1:0] hdr, int per, bit e_st, bit e_slip,
                              int e_slips, logic [15:0] e_bad);
    vec_t v;
    v.name = name; v.n = n; v.rd = rd; v.vmode = vmode; v.hdr = hdr;
    v.per = per; v.e_st = e_st; v.e_slip = e_slip; v.e_slips = e_slips;
    v.e_bad = e_bad;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_main();
    int slips;
    int vcnt;
    bit v;
    m_if.rx_reset_done   = 1'b0;
    m_if.rx_header_valid = 1'b0;
    m_if.rx_header       = 2'b00;
    rst_m = 1'b1;
    step();
    step();
    chk("m_reset.status", 32'(m_if.rx_status), 32'd0);
    chk("m_reset.slip",   32'(m_if.rx_slip),   32'd0);
    chk("m_reset.bad",    32'(m_if.bad_hdr_cnt), 32'd0);
    rst_m = 1'b0;

    foreach (tbl[k]) begin
      slips = 0;
      vcnt  = 0;
      for (int i = 0; i < tbl[k].n; i++) begin
        case (tbl[k].vmode)
          0:       v = 1'b0;
          1:       v = 1'b1;
          default: v = ((i % 2) == 0);
        endcase
        m_if.rx_reset_done   = tbl[k].rd;
        m_if.rx_header_valid = v;
        if (!v)
          m_if.rx_header = 2'b11;
        else if (tbl[k].per != 0 && (vcnt % tbl[k].per) == tbl[k].per - 1)
          m_if.rx_header = 2'b11;
        else
          m_if.rx_header = tbl[k].hdr;
        if (v) vcnt++;
        step();
        if (m_if.rx_slip === 1'b1) slips++;
      end
      chk($sformatf("%s.status", tbl[k].name), 32'(m_if.rx_status), 32'(tbl[k].e_st));
      chk($sformatf("%s.slip", tbl[k].name), 32'(m_if.rx_slip), 32'(tbl[k].e_slip));
      chk($sformatf("%s.slips", tbl[k].name), 32'(slips), 32'(tbl[k].e_slips));
      chk($sformatf("%s.bad", tbl[k].name), 32'(m_if.bad_hdr_cnt), 32'(tbl[k].e_bad));
    end
  endtask

  task automatic run_sat();
    s_if.rx_reset_done   = 1'b1;
    s_if.rx_header_valid = 1'b0;
    s_if.rx_header       = 2'b01;
    rst_s = 1'b1;
    step();
    step();
    chk("s_reset.status", 32'(s_if.rx_status), 32'd0);
    rst_s = 1'b0;
    step();  // IDLE -> HUNT
    // Each round: 1 good header locks, 255 bad headers fill the window and
    // reach BAD_MAX together, dropping lock and adding 255 to the count.
    for (int r = 1; r <= 258; r++) begin
      s_if.rx_header_valid = 1'b1;
      s_if.rx_header       = 2'b01;
      step();
      if (r == 1) chk("s_lock1.status", 32'(s_if.rx_status), 32'd1);
      s_if.rx_header = 2'b11;
      for (int b = 0; b < 255; b++) step();
      if (r == 1)   chk("s_round1.bad", 32'(s_if.bad_hdr_cnt), 32'h00FF);
      if (r == 256) chk("s_round256.bad", 32'(s_if.bad_hdr_cnt), 32'hFF00);
      if (r == 257) chk("s_round257.bad", 32'(s_if.bad_hdr_cnt), 32'hFFFF);
      if (r == 258) begin
        chk("s_round258.bad",    32'(s_if.bad_hdr_cnt), 32'hFFFF);
        chk("s_round258.status", 32'(s_if.rx_status),   32'd0);
      end
    end
    // Now hunting: a bad header issues a slip
    s_if.rx_header = 2'b00;
    step();
    chk("s_slip.slip", 32'(s_if.rx_slip), 32'd1);
    // Reset while the slip pulse is high
    rst_s = 1'b1;
    s_if.rx_header_valid = 1'b0;
    step();
    chk("s_rst_slip.slip",   32'(s_if.rx_slip),     32'd0);
    chk("s_rst_slip.bad",    32'(s_if.bad_hdr_cnt), 32'd0);
    chk("s_rst_slip.status", 32'(s_if.rx_status),   32'd0);
    rst_s = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //                 name           n     rd vm hdr    per st sl nsl bad
    tbl.push_back(mk("idle_hold",     3,    1'b0, 1, 2'b01, 0,  1'b0, 1'b0, 0, 16'd0));
    tbl.push_back(mk("to_hunt",       1,    1'b1, 0, 2'b01, 0,  1'b0, 1'b0, 0, 16'd0));
    tbl.push_back(mk("hunt63",        63,   1'b1, 1, 2'b01, 0,  1'b0, 1'b0, 0, 16'd0));
    tbl.push_back(mk("lock64",        1,    1'b1, 1, 2'b01, 0,  1'b1, 1'b0, 0, 16'd0));
    tbl.push_back(mk("win1_15bad",    1024, 1'b1, 1, 2'b01, 68, 1'b1, 1'b0, 0, 16'd15));
    tbl.push_back(mk("win2_15bad",    959,  1'b1, 1, 2'b01, 60, 1'b1, 1'b0, 0, 16'd30));
    tbl.push_back(mk("win2_16th",     1,    1'b1, 1, 2'b00, 0,  1'b0, 1'b0, 0, 16'd31));
    tbl.push_back(mk("relock63",      63,   1'b1, 1, 2'b01, 0,  1'b0, 1'b0, 0, 16'd31));
    tbl.push_back(mk("relock64",      1,    1'b1, 1, 2'b01, 0,  1'b1, 1'b0, 0, 16'd31));
    tbl.push_back(mk("rd_drop",       1,    1'b0, 1, 2'b01, 0,  1'b0, 1'b0, 0, 16'd31));
    tbl.push_back(mk("rd_back",       1,    1'b1, 0, 2'b01, 0,  1'b0, 1'b0, 0, 16'd31));
    tbl.push_back(mk("hunt10",        10,   1'b1, 1, 2'b01, 0,  1'b0, 1'b0, 0, 16'd31));
    tbl.push_back(mk("hunt_bad",      1,    1'b1, 1, 2'b11, 0,  1'b0, 1'b1, 1, 16'd31));
    tbl.push_back(mk("slip_fall",     1,    1'b1, 1, 2'b00, 0,  1'b0, 1'b0, 0, 16'd31));
    tbl.push_back(mk("slip_wait",     31,   1'b1, 1, 2'b00, 0,  1'b0, 1'b0, 0, 16'd31));
    tbl.push_back(mk("fresh63",       63,   1'b1, 1, 2'b10, 0,  1'b0, 1'b0, 0, 16'd31));
    tbl.push_back(mk("fresh64",       1,    1'b1, 1, 2'b10, 0,  1'b1, 1'b0, 0, 16'd31));
    tbl.push_back(mk("rd_drop2",      1,    1'b0, 1, 2'b01, 0,  1'b0, 1'b0, 0, 16'd31));
    tbl.push_back(mk("rd_back2",      1,    1'b1, 0, 2'b01, 0,  1'b0, 1'b0, 0, 16'd31));
    tbl.push_back(mk("stall63",       126,  1'b1, 2, 2'b01, 0,  1'b0, 1'b0, 0, 16'd31));
    tbl.push_back(mk("stall64",       1,    1'b1, 2, 2'b01, 0,  1'b1, 1'b0, 0, 16'd31));
    tbl.push_back(mk("win_fill",      1023, 1'b1, 1, 2'b01, 68, 1'b1, 1'b0, 0, 16'd46));
    tbl.push_back(mk("win_end_loss",  1,    1'b1, 1, 2'b11, 0,  1'b0, 1'b0, 0, 16'd47));
    tbl.push_back(mk("after_loss63",  63,   1'b1, 1, 2'b01, 0,  1'b0, 1'b0, 0, 16'd47));
    tbl.push_back(mk("after_loss64",  1,    1'b1, 1, 2'b01, 0,  1'b1, 1'b0, 0, 16'd47));

    fork
      run_main();
      run_sat();
    join

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_block_lock_mon.md
Name: rx_block_lock_mon

Overview:
- Monitors 64b/66b sync headers from the GT RX gearbox and acquires block lock by issuing gearbox slips.
- Drives rx_status, which is high only while the link is block-locked.
- rx_status feeds the downstream RX reset sequencer, which re-issues gtwiz_rx_reset when rx_status drops.
- Also keeps a saturating bad-header count for debug/ILA.

Parameters:
- LOCK_CNT, 64: consecutive good headers required to declare lock (>=1).
- WINDOW, 1024: valid headers per error-monitoring window while locked (>=1).
- BAD_MAX, 16: bad headers within one window that cause loss of lock (1..WINDOW).
- SLIP_WAIT, 32: clock cycles to wait after a slip before hunting again (>=1).

Ports:
- clk  in  1  RX user clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- rx_reset_done  in  1  GT RX reset-done (gtwiz_reset_rx_done), already synchronous to clk.
- rx_header_valid  in  1  rx_header is valid this cycle.
- rx_header  in  2  66b sync header; 2'b01 and 2'b10 are good, 2'b00 and 2'b11 are bad.
- rx_status  out  1  block locked; consumed by the RX reset sequencer.
- rx_slip  out  1  one-cycle gearbox slip request.
- bad_hdr_cnt  out  16  saturating count of bad headers seen while LOCKED.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: state=IDLE; rx_status=0; rx_slip=0; bad_hdr_cnt=0; all internal counters=0.
- States: IDLE, HUNT, SLIP_WAIT, LOCKED. Use one-hot encoding; any illegal encoding goes to IDLE next cycle.
- rx_status is a direct decode of state==LOCKED, with no extra register stage.
- Global rule: if rx_reset_done=0 in any state, next state is IDLE, counters clear, rx_slip=0. This overrides all other transitions.
- IDLE: when rx_reset_done=1, go to HUNT with good_cnt=0.
- HUNT, on valid good header: good_cnt+1. When this is the LOCK_CNT-th consecutive good header, go to LOCKED with win_cnt=0 and bad_cnt=0.
- HUNT, on valid bad header: good_cnt=0, go to SLIP_WAIT, rx_slip=1 for exactly the first cycle in SLIP_WAIT.
- HUNT, cycles with rx_header_valid=0: ignored; good_cnt holds.
- SLIP_WAIT: a cycle counter advances every clk regardless of valid. After exactly SLIP_WAIT cycles in SLIP_WAIT, go to HUNT with good_cnt=0. Headers are ignored in this state.
- LOCKED, each valid header: win_cnt+1; a bad header also increments bad_cnt and bad_hdr_cnt. bad_hdr_cnt saturates at 16'hFFFF and is cleared only by reset.
- LOCKED, bad header bringing bad_cnt to BAD_MAX: go to HUNT with good_cnt=0. rx_status falls on the next cycle. No slip is issued on loss of lock.
- LOCKED, valid header bringing win_cnt to WINDOW without hitting BAD_MAX: clear win_cnt and bad_cnt; stay LOCKED.
- Simultaneous: if one header both completes the window and reaches BAD_MAX, loss of lock wins.
- Counter widths: $clog2(param+1). No wrap is possible because each counter clears at its terminal value.
- Reset asserted mid-operation (any state, including during a slip pulse): next cycle matches the reset values exactly.

Test Plan:
- Reset, then rx_reset_done=1 with 64 consecutive valid 2'b01 headers → rx_status=1 on the cycle after the 64th header; rx_slip never asserted.
- In HUNT after 10 good headers, one 2'b11 header → rx_slip high for exactly 1 cycle. Headers are ignored for 32 cycles, then HUNT restarts, and lock needs 64 fresh good headers.
- Locked, with 15 bad headers spread across one 1024-header window → stays locked; bad_hdr_cnt=15. Next window with 16 bad → rx_status=0 the cycle after the 16th bad header; state is HUNT.
- Locked, drop rx_reset_done for 1 cycle → rx_status=0 next cycle and state is IDLE. Relock takes 64 good headers after rx_reset_done returns.
- Stalled input: good headers with rx_header_valid toggling 1/0 in HUNT → lock after 64 valid headers (about 128 cycles); invalid cycles affect no counter.
- Force bad_hdr_cnt near saturation (long error stream, relocking repeatedly) → holds at 16'hFFFF. Assert reset during a slip pulse → rx_slip=0, bad_hdr_cnt=0, rx_status=0 on the next cycle.
